// File: rtl/idl_pkg.sv
// Shared types and constants for the input data buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package idl_pkg;

    // Output bus indices as wired into the datapath
    typedef enum logic [1:0] {
        BUS_DB  = 2'd0,
        BUS_ADL = 2'd1,
        BUS_ADH = 2'd2
    } idl_bus_e;

    // Undriven buses float to the precharged level: all ones
    localparam logic      IDL_PRECHARGE_BIT  = 1'b1;
    localparam logic [7:0] IDL_PRECHARGE     = {8{IDL_PRECHARGE_BIT}};

    typedef logic [7:0] idl_byte_t;

endpackage : idl_pkg

// File: rtl/idl_fifo_core.sv
// Byte FIFO storage with pointers, registered count and empty/full flags.
// Latency: a pushed byte is readable at the head one cycle later.
// Backpressure: none internally; the caller only issues legal push/pop.
module idl_fifo_core #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        wr_dat_i,
    output logic [DATA_W-1:0]        rd_dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic [PTR_W-1:0] wr_addr;

    // Next pointers/count; a flush rewinds everything and a concurrent push lands in slot 0
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_addr  = wr_ptr_q;
        if (flush_i) begin
            wr_addr  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = push_i ? PTR_W'(1) : '0;
            count_d  = push_i ? CNT_W'(1) : '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    // Pointer, count and flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Storage is deliberately left out of reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_addr] <= wr_dat_i;
    end

    assign rd_dat_o = mem_q[rd_ptr_q];
    assign count_o  = count_q;
    assign empty_o  = empty_q;
    assign full_o   = full_q;

endmodule : idl_fifo_core

// File: rtl/input_data_buffer.sv
// Pin-side byte prefetch FIFO feeding the DB/ADL/ADH buses; optional IDL_BYPASS_EN forwards into an empty FIFO.
// Latency: capture visible on the buses next cycle (same cycle with IDL_BYPASS_EN when empty).
// Backpressure: none; captures while full are dropped (sticky overflow), pops while empty are ignored (sticky underflow).
module input_data_buffer
    import idl_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 4,
    parameter int                N_OUT     = 3,
    parameter logic [DATA_W-1:0] PRECHARGE = {DATA_W{IDL_PRECHARGE_BIT}}
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_W-1:0]              data_IN,
    input  logic                           capture_EN,
    input  logic                           pop_EN,
    input  logic                           flush_EN,
    input  logic [N_OUT-1:0]               drive_EN,
    output logic [N_OUT-1:0][DATA_W-1:0]   bus_OUT,
    output logic [$clog2(DEPTH):0]         count_OUT,
    output logic                           empty_OUT,
    output logic                           full_OUT,
    output logic                           overflow_OUT,
    output logic                           underflow_OUT
);

    logic [DATA_W-1:0]      fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;

    logic                   pop_req;
    logic                   bypass_consume;
    logic                   push_acc;
    logic                   pop_acc;
    logic [DATA_W-1:0]      src;

    logic [DATA_W-1:0]      last_q, last_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;

    // Qualify strobes: flush outranks pop; a full FIFO only accepts a capture alongside a pop
    always_comb begin
        pop_req = pop_EN && !flush_EN;
`ifdef IDL_BYPASS_EN
        // Pop against an empty FIFO takes the byte being captured this very cycle
        bypass_consume = pop_req && fifo_empty && capture_EN;
`else
        bypass_consume = 1'b0;
`endif
        push_acc = capture_EN && (flush_EN || !fifo_full || pop_req) && !bypass_consume;
        pop_acc  = pop_req && !fifo_empty;
    end

    // Last-consumed byte and sticky error flags
    always_comb begin
        last_d      = last_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (pop_acc)             last_d = fifo_head;
        else if (bypass_consume) last_d = data_IN;
        if (flush_EN) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (capture_EN && fifo_full && !pop_req)           overflow_d  = 1'b1;
            if (pop_req && fifo_empty && !bypass_consume)      underflow_d = 1'b1;
        end
    end

    // Top-level state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            last_q      <= last_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    idl_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush_i  (flush_EN),
        .push_i   (push_acc),
        .pop_i    (pop_acc),
        .wr_dat_i (data_IN),
        .rd_dat_o (fifo_head),
        .count_o  (fifo_count),
        .empty_o  (fifo_empty),
        .full_o   (fifo_full)
    );

    // Source byte: head entry, or the last consumed byte once the FIFO drains
    always_comb begin
        src = fifo_empty ? last_q : fifo_head;
`ifdef IDL_BYPASS_EN
        if (fifo_empty && capture_EN) src = data_IN;
`endif
    end

    // Per-bus drive muxes; an undriven bus reads the precharge level
    always_comb begin
        bus_OUT = {N_OUT{PRECHARGE}};
        for (int i = 0; i < N_OUT; i++) begin
            bus_OUT[i] = drive_EN[i] ? src : PRECHARGE;
        end
    end

    assign count_OUT     = fifo_count;
    assign empty_OUT     = fifo_empty;
    assign full_OUT      = fifo_full;
    assign overflow_OUT  = overflow_q;
    assign underflow_OUT = underflow_q;

endmodule : input_data_buffer

// File: tb/tb_input_data_buffer.sv
// Directed self-checking bench for input_data_buffer.
// Latency: n/a.
// Backpressure: n/a.
module tb_input_data_buffer;

`ifdef IDL_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic [7:0]      data_in;
    logic            capture_en;
    logic            pop_en;
    logic            flush_en;
    logic [2:0]      drive_en;
    logic [2:0][7:0] bus_out;
    logic [2:0]      count_out;
    logic            empty_out;
    logic            full_out;
    logic            overflow_out;
    logic            underflow_out;

    int checks = 0;
    int passed = 0;

    input_data_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .data_IN       (data_in),
        .capture_EN    (capture_en),
        .pop_EN        (pop_en),
        .flush_EN      (flush_en),
        .drive_EN      (drive_en),
        .bus_OUT       (bus_out),
        .count_OUT     (count_out),
        .empty_OUT     (empty_out),
        .full_OUT      (full_out),
        .overflow_OUT  (overflow_out),
        .underflow_OUT (underflow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        capture_en = 1'b1;
        data_in    = b;
        cyc();
        capture_en = 1'b0;
    endtask

    task automatic test_reset();
        push_byte(8'h5A);
        push_byte(8'h6B);
        drive_en = 3'b001;
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (count_out !== 3'd0) $display("FAIL reset_count got %0d want 0", count_out); else passed++;
        checks++;
        if (empty_out !== 1'b1) $display("FAIL reset_empty got %b want 1", empty_out); else passed++;
        checks++;
        if (bus_out[0] !== 8'h00) $display("FAIL reset_db got %h want 00", bus_out[0]); else passed++;
        checks++;
        if (bus_out[1] !== 8'hFF) $display("FAIL reset_adl got %h want ff", bus_out[1]); else passed++;
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_fill_wrap();
        logic [7:0] exp_q [4];
        exp_q = '{8'h33, 8'h44, 8'h55, 8'h66};
        drive_en = 3'b001;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        checks++;
        if (full_out !== 1'b1 || count_out !== 3'd4)
            $display("FAIL fill_full got full=%b cnt=%0d want full=1 cnt=4", full_out, count_out); else passed++;
        checks++;
        if (bus_out[0] !== 8'h11) $display("FAIL fill_head got %h want 11", bus_out[0]); else passed++;
        pop_en = 1'b1;
        cyc();
        cyc();
        pop_en = 1'b0;
        checks++;
        if (count_out !== 3'd2) $display("FAIL pop2_count got %0d want 2", count_out); else passed++;
        push_byte(8'h55);
        push_byte(8'h66);
        checks++;
        if (full_out !== 1'b1) $display("FAIL wrap_full got %b want 1", full_out); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus_out[0] !== exp_q[i]) $display("FAIL wrap_order%0d got %h want %h", i, bus_out[0], exp_q[i]); else passed++;
            pop_en = 1'b1;
            cyc();
            pop_en = 1'b0;
        end
        checks++;
        if (empty_out !== 1'b1 || bus_out[0] !== 8'h66)
            $display("FAIL drain_last got empty=%b db=%h want empty=1 db=66", empty_out, bus_out[0]); else passed++;
    endtask

    task automatic test_overflow();
        drive_en = 3'b001;
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        push_byte(8'h04);
        push_byte(8'h99);
        checks++;
        if (overflow_out !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow_out); else passed++;
        checks++;
        if (count_out !== 3'd4 || bus_out[0] !== 8'h01)
            $display("FAIL ovf_unchanged got cnt=%0d head=%h want cnt=4 head=01", count_out, bus_out[0]); else passed++;
        capture_en = 1'b1;
        data_in    = 8'h77;
        pop_en     = 1'b1;
        cyc();
        capture_en = 1'b0;
        pop_en     = 1'b0;
        checks++;
        if (count_out !== 3'd4 || bus_out[0] !== 8'h02)
            $display("FAIL full_pushpop got cnt=%0d head=%h want cnt=4 head=02", count_out, bus_out[0]); else passed++;
        flush_en = 1'b1;
        cyc();
        flush_en = 1'b0;
        checks++;
        if (overflow_out !== 1'b0 || count_out !== 3'd0 || empty_out !== 1'b1)
            $display("FAIL flush_clear got ovf=%b cnt=%0d empty=%b want 0/0/1", overflow_out, count_out, empty_out); else passed++;
        checks++;
        if (bus_out[0] !== 8'h01) $display("FAIL flush_keeps_last got %h want 01", bus_out[0]); else passed++;
    endtask

    task automatic test_empty_hold();
        push_byte(8'hA5);
        drive_en = 3'b101;
        pop_en   = 1'b1;
        cyc();
        pop_en   = 1'b0;
        checks++;
        if (empty_out !== 1'b1 || bus_out[0] !== 8'hA5 || bus_out[2] !== 8'hA5)
            $display("FAIL hold_value got empty=%b db=%h adh=%h want 1/a5/a5", empty_out, bus_out[0], bus_out[2]); else passed++;
        checks++;
        if (bus_out[1] !== 8'hFF) $display("FAIL hold_adl_precharge got %h want ff", bus_out[1]); else passed++;
        pop_en = 1'b1;
        cyc();
        pop_en = 1'b0;
        checks++;
        if (underflow_out !== 1'b1 || bus_out[0] !== 8'hA5 || count_out !== 3'd0)
            $display("FAIL underflow got udf=%b db=%h cnt=%0d want 1/a5/0", underflow_out, bus_out[0], count_out); else passed++;
    endtask

    task automatic test_flush_capture();
        drive_en = 3'b001;
        push_byte(8'h10);
        push_byte(8'h20);
        push_byte(8'h30);
        checks++;
        if (count_out !== 3'd3) $display("FAIL fc_pre_count got %0d want 3", count_out); else passed++;
        flush_en   = 1'b1;
        capture_en = 1'b1;
        data_in    = 8'hE7;
        cyc();
        flush_en   = 1'b0;
        capture_en = 1'b0;
        checks++;
        if (count_out !== 3'd1 || bus_out[0] !== 8'hE7 || empty_out !== 1'b0)
            $display("FAIL fc_sole got cnt=%0d head=%h empty=%b want 1/e7/0", count_out, bus_out[0], empty_out); else passed++;
        checks++;
        if (underflow_out !== 1'b0) $display("FAIL fc_udf_clear got %b want 0", underflow_out); else passed++;
    endtask

    task automatic test_bypass();
        drive_en = 3'b001;
        pop_en   = 1'b1;
        cyc();
        pop_en   = 1'b0;
        checks++;
        if (empty_out !== 1'b1 || bus_out[0] !== 8'hE7)
            $display("FAIL byp_pre got empty=%b db=%h want 1/e7", empty_out, bus_out[0]); else passed++;
        capture_en = 1'b1;
        data_in    = 8'h3C;
        #1;
        checks++;
        if (bus_out[0] !== (BYP ? 8'h3C : 8'hE7))
            $display("FAIL byp_same_cycle got %h want %h", bus_out[0], (BYP ? 8'h3C : 8'hE7)); else passed++;
        cyc();
        capture_en = 1'b0;
        checks++;
        if (bus_out[0] !== 8'h3C || count_out !== 3'd1)
            $display("FAIL byp_next_cycle got db=%h cnt=%0d want 3c/1", bus_out[0], count_out); else passed++;
        pop_en = 1'b1;
        cyc();
        capture_en = 1'b1;
        data_in    = 8'h5D;
        cyc();
        capture_en = 1'b0;
        pop_en     = 1'b0;
        checks++;
        if (count_out !== (BYP ? 3'd0 : 3'd1) || underflow_out !== ~BYP)
            $display("FAIL empty_pushpop got cnt=%0d udf=%b want cnt=%0d udf=%b",
                     count_out, underflow_out, (BYP ? 0 : 1), ~BYP); else passed++;
        checks++;
        if (bus_out[0] !== 8'h5D) $display("FAIL empty_pushpop_val got %h want 5d", bus_out[0]); else passed++;
    endtask

    initial begin
        reset      = 1'b1;
        data_in    = 8'h00;
        capture_en = 1'b0;
        pop_en     = 1'b0;
        flush_en   = 1'b0;
        drive_en   = 3'b000;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        test_reset();
        test_fill_wrap();
        test_overflow();
        test_empty_hold();
        test_flush_capture();
        test_bypass();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_input_data_buffer
